// File: rtl/timer_pkg.sv
// Shared definitions for the kitchen-timer countdown block: state encodings,
// default timing constants, counter width and the standard mode durations.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    ALARM  = 3'd4
  } state_t;

  localparam int DEF_CLK_PER_SEC = 50000000;
  localparam int DEF_ALARM_SEC   = 10;
  localparam int DEF_BEEP_HALF   = 12500000;
  localparam int DEF_CNT_W       = 8;

  localparam int MODE_SEC_60  = 60;
  localparam int MODE_SEC_120 = 120;
  localparam int MODE_SEC_180 = 180;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a once-per-second terminal indication.
// The count freezes while en is low so a paused countdown keeps its partial
// second; clr restarts the second from zero.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_PER_SEC = DEF_CLK_PER_SEC
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = cnt_width(CLK_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] cnt;

  // Terminal flag: the owner registers it, so it lands one edge later.
  assign tick = en && (cnt == TERM);

  // Free-running 0..CLK_PER_SEC-1 counter, held when disabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_countdown_ctrl.sv
// Countdown sequencer for the kitchen timer: loads a duration, counts whole
// seconds with pause/resume, flags zero, then drives a pulsed buzzer until
// the alarm times out or is acknowledged. All outputs are registers.
module timer_countdown_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ALARM_SEC   = DEF_ALARM_SEC,
  parameter int BEEP_HALF   = DEF_BEEP_HALF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             alarm_ack,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] sec_remaining,
  output logic             sec_tick,
  output logic             flag_sec_equal_zero,
  output logic             buzzer,
  output logic             end_alarm
);

  localparam int AW = cnt_width(ALARM_SEC + 1);
  localparam int BW = cnt_width(BEEP_HALF);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_HALF - 1);

  // Kept as a raw 3-bit vector so illegal codes 5..7 are representable and
  // can be steered back to IDLE.
  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic          do_load;
  logic          do_go;
  logic          do_dec;
  logic          to_alarm;
  logic          fin;
  logic          abort;
  logic          pre_en;
  logic          pre_clr;
  logic          pre_tick;
  logic [BW-1:0] beep_cnt;
  logic [AW-1:0] alarm_cnt;

  assign state   = state_q;
  assign pre_en  = (state_q == RUN) || (state_q == ALARM);
  assign pre_clr = abort || do_go;

  tick_prescaler #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (pre_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes; stop outranks everything, an ignored
  // load does not mask the lower-priority inputs.
  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_go    = 1'b0;
    do_dec   = 1'b0;
    to_alarm = 1'b0;
    fin      = 1'b0;
    abort    = 1'b0;
    if (stop) begin
      abort   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (load && (load_value != '0)) begin
            do_load = 1'b1;
            state_d = LOADED;
          end
        end
        LOADED: begin
          if (load && (load_value != '0)) begin
            do_load = 1'b1;
          end else if (start) begin
            do_go   = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (pre_tick && (sec_remaining != '0)) begin
            do_dec = 1'b1;
            if (sec_remaining == CNT_W'(1)) begin
              to_alarm = 1'b1;
              state_d  = ALARM;
            end
          end
          if (!to_alarm && pause) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end
        end
        ALARM: begin
          if (alarm_ack || (pre_tick && (alarm_cnt == ALARM_LAST))) begin
            fin     = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Seconds counter, pulse outputs, buzzer cadence and alarm duration.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      sec_remaining       <= '0;
      sec_tick            <= 1'b0;
      flag_sec_equal_zero <= 1'b0;
      buzzer              <= 1'b0;
      end_alarm           <= 1'b0;
      beep_cnt            <= '0;
      alarm_cnt           <= '0;
    end else begin
      sec_tick            <= pre_tick;
      flag_sec_equal_zero <= to_alarm;
      end_alarm           <= fin;
      if (do_load) begin
        sec_remaining <= load_value;
      end else if (do_dec) begin
        sec_remaining <= sec_remaining - 1'b1;
      end
      if (to_alarm) begin
        buzzer    <= 1'b1;
        beep_cnt  <= '0;
        alarm_cnt <= '0;
      end else if (fin) begin
        buzzer <= 1'b0;
      end else if (state_q == ALARM) begin
        if (beep_cnt == BEEP_LAST) begin
          beep_cnt <= '0;
          buzzer   <= ~buzzer;
        end else begin
          beep_cnt <= beep_cnt + 1'b1;
        end
        if (pre_tick) begin
          alarm_cnt <= alarm_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_countdown_ctrl.sv
// Bench for timer_countdown_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_timer_countdown_ctrl;

  localparam int CPS = 4;
  localparam int ASEC = 3;
  localparam int BH = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, load, start, pause, stop, alarm_ack;
  logic [CW-1:0] load_value;
  logic [2:0]    state;
  logic [CW-1:0] sec_remaining;
  logic          sec_tick, flag_sec_equal_zero, buzzer, end_alarm;

  int checks = 0;
  int errors = 0;

  timer_countdown_ctrl #(
    .CLK_PER_SEC(CPS), .CNT_W(CW), .ALARM_SEC(ASEC), .BEEP_HALF(BH)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .stop(stop), .alarm_ack(alarm_ack),
    .state(state), .sec_remaining(sec_remaining), .sec_tick(sec_tick),
    .flag_sec_equal_zero(flag_sec_equal_zero), .buzzer(buzzer),
    .end_alarm(end_alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rst, ld; logic [7:0] lv; logic st, ps, sp, ack;
    int e_state, e_rem; bit e_tick, e_flag, e_buz, e_end;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int es, input int er,
                           input bit et, input bit ef, input bit eb, input bit ee);
    chk({tag, ".state"}, 32'(state), es);
    chk({tag, ".sec_remaining"}, 32'(sec_remaining), er);
    chk({tag, ".sec_tick"}, 32'(sec_tick), 32'(et));
    chk({tag, ".flag_zero"}, 32'(flag_sec_equal_zero), 32'(ef));
    chk({tag, ".buzzer"}, 32'(buzzer), 32'(eb));
    chk({tag, ".end_alarm"}, 32'(end_alarm), 32'(ee));
  endtask

  task automatic apply(input logic r, input logic l, input logic [7:0] v,
                       input logic s, input logic p, input logic sp, input logic a);
    reset = r; load = l; load_value = v; start = s; pause = p; stop = sp; alarm_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    apply(0, 0, 8'd0, 0, 0, 0, 0);
  endtask

  // Behavioural model: mode 0..4, seconds left, elapsed cycles of the
  // current second, cycles and seconds since the alarm started.
  int m_state, m_rem, m_phase, m_acyc, m_asec;
  bit e_tick, e_flag, e_buz, e_end;

  task automatic model_step(input bit r, input bit l, input int v,
                            input bit s, input bit p, input bit sp, input bit a);
    e_tick = 0; e_flag = 0; e_end = 0;
    if (r || sp) begin
      m_state = 0; m_rem = 0; m_phase = 0; e_buz = 0;
    end else begin
      case (m_state)
        0: if (l && v != 0) begin m_rem = v; m_state = 1; end
        1: begin
          if (l && v != 0) m_rem = v;
          else if (s) begin m_state = 2; m_phase = 0; end
        end
        2: begin
          m_phase++;
          if (m_phase == CPS) begin
            m_phase = 0; e_tick = 1; m_rem--;
            if (m_rem == 0) begin
              e_flag = 1; m_state = 4; m_acyc = 0; m_asec = 0; e_buz = 1;
            end
          end
          if (m_state == 2 && p) m_state = 3;
        end
        3: if (s) m_state = 2;
        default: begin
          m_acyc++; m_phase++;
          if (m_phase == CPS) begin m_phase = 0; e_tick = 1; m_asec++; end
          if (a || m_asec == ASEC) begin
            e_end = 1; e_buz = 0; m_state = 0;
          end else begin
            e_buz = ((m_acyc / BH) % 2) == 0;
          end
        end
      endcase
    end
  endtask

  initial begin
    //         rst ld lv   st ps sp ack  state rem tick flag buz end
    vecs[0]  = '{1, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 8'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 8'd3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0};
    vecs[4]  = '{0, 1, 8'd6, 1, 0, 0, 0, 1, 6, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 8'd0, 1, 0, 0, 0, 2, 6, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 8'd0, 0, 0, 0, 0, 2, 6, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 8'd0, 0, 0, 0, 0, 2, 6, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 8'd0, 0, 0, 0, 0, 2, 6, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 8'd0, 0, 0, 0, 0, 2, 5, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 8'd0, 0, 0, 0, 0, 2, 5, 0, 0, 0, 0};
    vecs[11] = '{0, 1, 8'd9, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ps,
            vecs[i].sp, vecs[i].ack);
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_rem,
                vecs[i].e_tick, vecs[i].e_flag, vecs[i].e_buz, vecs[i].e_end);
    end

    // Countdown from 3 into ALARM, then alarm timeout.
    apply(0, 1, 8'd3, 0, 0, 0, 0);
    check_all("cd.load", 1, 3, 0, 0, 0, 0);
    apply(0, 0, 8'd0, 1, 0, 0, 0);
    check_all("cd.start", 2, 3, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      idle1();
      check_all($sformatf("cd.c%0d", c), (c == 12) ? 4 : 2, 3 - c / 4,
                (c % 4) == 0, c == 12, c == 12, 0);
    end
    for (int c = 1; c <= 12; c++) begin
      idle1();
      check_all($sformatf("alm.c%0d", c), (c == 12) ? 0 : 4, 0, (c % 4) == 0, 0,
                (c == 12) ? 1'b0 : (((c / 2) % 2) == 0), c == 12);
    end
    idle1();
    check_all("alm.after", 0, 0, 0, 0, 0, 0);

    // Pause two cycles into a second, hold, resume.
    apply(0, 1, 8'd2, 0, 0, 0, 0);
    apply(0, 0, 8'd0, 1, 0, 0, 0);
    check_all("pr.run", 2, 2, 0, 0, 0, 0);
    idle1();
    apply(0, 0, 8'd0, 0, 1, 0, 0);
    check_all("pr.pause", 3, 2, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      idle1();
      check_all($sformatf("pr.hold%0d", c), 3, 2, 0, 0, 0, 0);
    end
    apply(0, 0, 8'd0, 1, 0, 0, 0);
    check_all("pr.resume", 2, 2, 0, 0, 0, 0);
    idle1();
    check_all("pr.r1", 2, 2, 0, 0, 0, 0);
    idle1();
    check_all("pr.r2", 2, 1, 1, 0, 0, 0);
    apply(0, 0, 8'd0, 0, 0, 1, 0);
    check_all("pr.stop", 0, 0, 0, 0, 0, 0);

    // alarm_ack on the cycle before the timeout.
    apply(0, 1, 8'd1, 0, 0, 0, 0);
    apply(0, 0, 8'd0, 1, 0, 0, 0);
    for (int c = 1; c <= 4; c++) idle1();
    check_all("ack.alarm", 4, 0, 1, 1, 1, 0);
    for (int c = 1; c <= 10; c++) idle1();
    check_all("ack.c10", 4, 0, 0, 0, 0, 0);
    apply(0, 0, 8'd0, 0, 0, 0, 1);
    check_all("ack.end", 0, 0, 0, 0, 0, 1);
    idle1();
    check_all("ack.single", 0, 0, 0, 0, 0, 0);
    idle1();
    check_all("ack.quiet", 0, 0, 0, 0, 0, 0);

    // Reset while the buzzer is sounding.
    apply(0, 1, 8'd1, 0, 0, 0, 0);
    apply(0, 0, 8'd0, 1, 0, 0, 0);
    for (int c = 1; c <= 4; c++) idle1();
    check_all("rst.alarm", 4, 0, 1, 1, 1, 0);
    apply(1, 0, 8'd0, 0, 0, 0, 0);
    check_all("rst.edge", 0, 0, 0, 0, 0, 0);
    idle1();
    check_all("rst.after", 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    apply(1, 0, 8'd0, 0, 0, 0, 0);
    m_state = 0; m_rem = 0; m_phase = 0; m_acyc = 0; m_asec = 0; e_buz = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r, l, s, p, sp, a;
      int v;
      r  = ($urandom_range(0, 199) == 0);
      sp = ($urandom_range(0, 59) == 0);
      l  = ($urandom_range(0, 11) == 0);
      v  = $urandom_range(0, 4);
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 19) == 0);
      a  = ($urandom_range(0, 39) == 0);
      apply(r, l, 8'(v), s, p, sp, a);
      model_step(r, l, v, s, p, sp, a);
      check_all($sformatf("rnd%0d", n), m_state, m_rem, e_tick, e_flag, e_buz, e_end);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
